adbg_wb_xfer_ctrl: RTL and testbench
====================================

# adbg_wb_xfer_ctrl

Wishbone-side transaction sequencer for the advanced debug unit's bus module. It sits in the WB clock domain behind the toggle synchronizers that cross requests in from the TCK domain. It consumes the synchronized request level and clears it, then runs one classic Wishbone single cycle per request with byte-lane steering and a timeout. It returns completion to the TCK domain as a toggle and holds read data and a sticky error.

## Interface
- TIMEOUT_CYCLES, 1024: WB cycles allowed per bus access before it is aborted as an error (≥2).
- CLK  in  1  WB clock; the only clock.
- RSTN  in  1  asynchronous, active-low reset.
- REQ_DET  in  1  request level from the request synchronizer output; stays high until cleared.
- REQ_CLR  out  1  one-cycle pulse to the request synchronizer's clear input.
- ERR_CLR_DET  in  1  error-clear level from a second synchronizer output.
- ERR_CLR  out  1  one-cycle pulse clearing that synchronizer.
- XFER_FIRST  in  1  first word of a burst: load address from XFER_ADDR.
- XFER_ADDR  in  32  burst start byte address.
- XFER_WE  in  1  1 = write, 0 = read.
- XFER_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- XFER_WDATA  in  32  write data, right-justified.
- ACK_TOGGLE  out  1  flips once per completed request; goes to the TCK-side synchronizer toggle input.
- RDATA  out  32  last read data, right-justified, zero-extended.
- BUS_ERR  out  1  sticky error flag.
- WB_ADR_O  out  32;  WB_DAT_O  out  32;  WB_SEL_O  out  4;  WB_WE_O  out  1;  WB_CYC_O  out  1;  WB_STB_O  out  1.
- WB_CTI_O  out  3  constant 3'b000.
- WB_BTE_O  out  2  constant 2'b00.
- WB_DAT_I  in  32;  WB_ACK_I  in  1;  WB_ERR_I  in  1.

## Operation
- XFER_* are quasi-static: the TCK side holds them stable from its request toggle until it sees ACK_TOGGLE flip. The TCK side issues no new request before that flip; a request arriving during REQ_CLR is lost.
- States: IDLE, BUS.
- IDLE with REQ_DET=1:
  - Latch XFER_*.
  - Address = XFER_ADDR if XFER_FIRST, else the internal next-address register.
  - Pulse REQ_CLR on the next cycle.
  - If BUS_ERR=1, size=3, or the address is misaligned (half with a[0]=1; word with a[1:0]≠0): set BUS_ERR, flip ACK_TOGGLE, stay in IDLE, no bus cycle.
  - Otherwise go to BUS.
- BUS:
  - CYC/STB/WE/ADR/SEL/DAT are registered and held constant; the timeout counter counts from 0.
  - ACK_I: for reads, capture RDATA from the addressed lane. Next-address = address + (1 << size), wrapping modulo 2^32. Flip ACK_TOGGLE, return to IDLE.
  - ERR_I, or counter = TIMEOUT_CYCLES-1 without ACK: set BUS_ERR, flip ACK_TOGGLE, leave RDATA and next-address unchanged, return to IDLE.
  - ACK_I and ERR_I together: ERR wins.
- Lane steering is big-endian (OR1K):
  - Byte: SEL = 4'b1000 >> a[1:0]; WDATA[7:0] replicated to all 4 lanes.
  - Half: SEL = a[1] ? 0011 : 1100; WDATA[15:0] replicated twice.
  - Word: SEL = 1111.
  - Reads extract the same lane.
- ERR_CLR_DET=1 in IDLE: clear BUS_ERR and pulse ERR_CLR next cycle. Ignored in BUS until return to IDLE.
- When REQ_DET and ERR_CLR_DET are both pending in IDLE, error-clear is serviced first; the request is taken the following cycle.

## Timing
- All outputs are reset to 0: REQ_CLR, ERR_CLR, ACK_TOGGLE, RDATA, BUS_ERR, all WB_*. State = IDLE, next-address = 0.
- REQ_DET sampled high at edge N (IDLE):
  - CYC/STB high and REQ_CLR high during cycle N+1.
  - REQ_CLR is a single cycle.
- ACK_I sampled at edge M:
  - CYC/STB low from M+1; ACK_TOGGLE flipped and RDATA valid from M+1.
  - The earliest next request is sampled at M+1.
- Minimum request-to-toggle latency is 2 cycles with a zero-wait slave.
- Rejected request (error path): ACK_TOGGLE flips at N+1.
- Timeout: CYC drops exactly TIMEOUT_CYCLES cycles after it rose.
- Reset mid-BUS drops CYC/STB immediately (async); no toggle is issued.

## Structure
- Package adbg_wb_pkg:
  - state enum;
  - XFER_SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - CTI/BTE constants;
  - sel/steer and lane-extract functions.
- One sub-module, adbg_wb_lane: combinational SEL generation, write replication and read extraction, given size and a[1:0].
- The timeout counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Word write to 0x1000_0004, data 0xDEADBEEF, slave ACK after 3 waits -> SEL=1111, DAT_O=0xDEADBEEF, one REQ_CLR pulse at N+1, ACK_TOGGLE flips once, BUS_ERR=0.
- Byte-read burst, FIRST at 0x0000_0001, then 3 more requests, slave returns 0x11223344 -> SEL 0100, 0010, 0001, then 1000 at 0x4. RDATA = 0x22, 0x33, 0x44, then byte0 of the next word.
- Next-address wrap: word request at 0xFFFF_FFFC, then a non-FIRST request -> second access at 0x0000_0000.
- Slave never ACKs, TIMEOUT_CYCLES=8 -> CYC high exactly 8 cycles, BUS_ERR=1, toggle flips. The next request gets no bus cycle, only a toggle. After ERR_CLR_DET, an ERR_CLR pulse follows and the next request runs normally.
- Error handling on rejected or failed accesses:
  - Half write to 0x3 -> immediate error, no CYC.
  - XFER_SIZE=3 -> error.
  - ACK_I and ERR_I asserted together -> BUS_ERR=1, RDATA unchanged.
- RSTN low while in BUS -> all outputs 0 asynchronously. After release, a new request completes normally.

Source files
------------

// File: rtl/adbg_wb_pkg.sv
// Shared types, encodings and byte-lane helpers for the debug-unit
// Wishbone transaction sequencer. Lane numbering is big-endian (OR1K):
// byte address 0 lives on DAT[31:24].
package adbg_wb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } xfer_state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Byte-select for a given access size and low address bits.
    function automatic logic [3:0] wb_sel(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            SZ_BYTE: s = 4'b1000 >> a;
            SZ_HALF: s = a[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Replicate right-justified write data across every lane it may land on.
    function automatic logic [31:0] wb_steer(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Pull the addressed lane out of bus read data, right-justified and zero-extended.
    function automatic logic [31:0] wb_extract(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] dat);
        logic [31:0] r;
        case (size)
            SZ_BYTE: begin
                case (a)
                    2'd0:    r = {24'd0, dat[31:24]};
                    2'd1:    r = {24'd0, dat[23:16]};
                    2'd2:    r = {24'd0, dat[15:8]};
                    default: r = {24'd0, dat[7:0]};
                endcase
            end
            SZ_HALF: r = a[1] ? {16'd0, dat[15:0]} : {16'd0, dat[31:16]};
            default: r = dat;
        endcase
        return r;
    endfunction

    // Natural alignment check; reserved size is rejected separately.
    function automatic logic wb_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        case (size)
            SZ_HALF: m = a[0];
            SZ_WORD: m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/adbg_wb_xfer_ctrl_if.sv
// Classic Wishbone master bundle used by the debug-unit bus sequencer.
interface adbg_wb_xfer_ctrl_if;

    logic [31:0] WB_ADR_O;
    logic [31:0] WB_DAT_O;
    logic [3:0]  WB_SEL_O;
    logic        WB_WE_O;
    logic        WB_CYC_O;
    logic        WB_STB_O;
    logic [2:0]  WB_CTI_O;
    logic [1:0]  WB_BTE_O;
    logic [31:0] WB_DAT_I;
    logic        WB_ACK_I;
    logic        WB_ERR_I;

    modport master (
        output WB_ADR_O, WB_DAT_O, WB_SEL_O, WB_WE_O, WB_CYC_O, WB_STB_O,
               WB_CTI_O, WB_BTE_O,
        input  WB_DAT_I, WB_ACK_I, WB_ERR_I
    );

    modport slave (
        input  WB_ADR_O, WB_DAT_O, WB_SEL_O, WB_WE_O, WB_CYC_O, WB_STB_O,
               WB_CTI_O, WB_BTE_O,
        output WB_DAT_I, WB_ACK_I, WB_ERR_I
    );

endinterface

// File: rtl/adbg_wb_lane.sv
// Combinational big-endian byte-lane steering: select generation, write
// replication and read extraction for one access of a given size/offset.
module adbg_wb_lane
    import adbg_wb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_just
);

    assign sel         = wb_sel(size, addr_lo);
    assign wdata_lanes = wb_steer(size, wdata);
    assign rdata_just  = wb_extract(size, addr_lo, bus_rdata);

endmodule

// File: rtl/adbg_wb_xfer_ctrl.sv
// Wishbone-side sequencer for the debug unit bus module. Takes one
// synchronized request at a time, runs a single classic WB cycle with lane
// steering and a timeout, and reports completion as a toggle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for error-clear or request level; rejects bad ones
// ST_BUS  | CYC/STB held, waiting for ACK/ERR or timeout
module adbg_wb_xfer_ctrl
    import adbg_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                REQ_DET,
    output logic                REQ_CLR,
    input  logic                ERR_CLR_DET,
    output logic                ERR_CLR,
    input  logic                XFER_FIRST,
    input  logic [31:0]         XFER_ADDR,
    input  logic                XFER_WE,
    input  logic [1:0]          XFER_SIZE,
    input  logic [31:0]         XFER_WDATA,
    output logic                ACK_TOGGLE,
    output logic [31:0]         RDATA,
    output logic                BUS_ERR,
    adbg_wb_xfer_ctrl_if.master wb
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    xfer_state_t      state;
    logic [31:0]      next_addr;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic [31:0]      rdata_q;
    logic [3:0]       sel_q;
    logic [1:0]       size_q;
    logic [CNT_W-1:0] cnt;
    logic             cyc_q;
    logic             stb_q;
    logic             we_q;
    logic             req_clr_q;
    logic             err_clr_q;
    logic             ack_tog_q;
    logic             bus_err_q;

    logic [31:0]      req_addr;
    logic [1:0]       lane_size;
    logic [1:0]       lane_a;
    logic [3:0]       lane_sel;
    logic [31:0]      lane_wdata;
    logic [31:0]      lane_rdata;
    logic             reject;
    logic [31:0]      addr_inc;

    assign req_addr  = XFER_FIRST ? XFER_ADDR : next_addr;
    // In IDLE the lane logic steers the incoming request; in BUS it extracts
    // read data for the access already on the bus.
    assign lane_size = (state == ST_IDLE) ? XFER_SIZE : size_q;
    assign lane_a    = (state == ST_IDLE) ? req_addr[1:0] : adr_q[1:0];
    assign reject    = bus_err_q || (XFER_SIZE == SZ_RSVD) ||
                       wb_misaligned(XFER_SIZE, req_addr[1:0]);
    assign addr_inc  = 32'd1 << size_q;

    adbg_wb_lane u_lane (
        .size        (lane_size),
        .addr_lo     (lane_a),
        .wdata       (XFER_WDATA),
        .bus_rdata   (wb.WB_DAT_I),
        .sel         (lane_sel),
        .wdata_lanes (lane_wdata),
        .rdata_just  (lane_rdata)
    );

    // Sequencer: request intake, single WB cycle, timeout and sticky error.
    // The synchronizer levels are ignored while their clear pulse is out,
    // since they only fall on the edge that samples that pulse.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdata_q   <= '0;
            sel_q     <= '0;
            size_q    <= SZ_BYTE;
            cnt       <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            req_clr_q <= 1'b0;
            err_clr_q <= 1'b0;
            ack_tog_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            req_clr_q <= 1'b0;
            err_clr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ERR_CLR_DET && !err_clr_q) begin
                        bus_err_q <= 1'b0;
                        err_clr_q <= 1'b1;
                    end else if (REQ_DET && !req_clr_q) begin
                        req_clr_q <= 1'b1;
                        if (reject) begin
                            bus_err_q <= 1'b1;
                            ack_tog_q <= ~ack_tog_q;
                        end else begin
                            adr_q  <= req_addr;
                            sel_q  <= lane_sel;
                            dat_q  <= lane_wdata;
                            we_q   <= XFER_WE;
                            size_q <= XFER_SIZE;
                            cyc_q  <= 1'b1;
                            stb_q  <= 1'b1;
                            cnt    <= '0;
                            state  <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (wb.WB_ERR_I || (!wb.WB_ACK_I && (cnt == CNT_LAST))) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                        ack_tog_q <= ~ack_tog_q;
                        state     <= ST_IDLE;
                    end else if (wb.WB_ACK_I) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= lane_rdata;
                        end
                        next_addr <= adr_q + addr_inc;
                        ack_tog_q <= ~ack_tog_q;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign REQ_CLR     = req_clr_q;
    assign ERR_CLR     = err_clr_q;
    assign ACK_TOGGLE  = ack_tog_q;
    assign RDATA       = rdata_q;
    assign BUS_ERR     = bus_err_q;

    assign wb.WB_ADR_O = adr_q;
    assign wb.WB_DAT_O = dat_q;
    assign wb.WB_SEL_O = sel_q;
    assign wb.WB_WE_O  = we_q;
    assign wb.WB_CYC_O = cyc_q;
    assign wb.WB_STB_O = stb_q;
    assign wb.WB_CTI_O = WB_CTI_CLASSIC;
    assign wb.WB_BTE_O = WB_BTE_LINEAR;

endmodule

// File: tb/tb_adbg_wb_xfer_ctrl.sv
// Directed bench for adbg_wb_xfer_ctrl with a toggle-fed request/clear
// synchronizer model and a configurable Wishbone slave.
module tb_adbg_wb_xfer_ctrl;
    import adbg_wb_pkg::*;

    logic        CLK         = 1'b0;
    logic        RSTN        = 1'b0;
    logic        REQ_DET     = 1'b0;
    logic        REQ_CLR;
    logic        ERR_CLR_DET = 1'b0;
    logic        ERR_CLR;
    logic        XFER_FIRST  = 1'b0;
    logic [31:0] XFER_ADDR   = '0;
    logic        XFER_WE     = 1'b0;
    logic [1:0]  XFER_SIZE   = '0;
    logic [31:0] XFER_WDATA  = '0;
    logic        ACK_TOGGLE;
    logic [31:0] RDATA;
    logic        BUS_ERR;

    adbg_wb_xfer_ctrl_if wb();

    adbg_wb_xfer_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .REQ_DET     (REQ_DET),
        .REQ_CLR     (REQ_CLR),
        .ERR_CLR_DET (ERR_CLR_DET),
        .ERR_CLR     (ERR_CLR),
        .XFER_FIRST  (XFER_FIRST),
        .XFER_ADDR   (XFER_ADDR),
        .XFER_WE     (XFER_WE),
        .XFER_SIZE   (XFER_SIZE),
        .XFER_WDATA  (XFER_WDATA),
        .ACK_TOGGLE  (ACK_TOGGLE),
        .RDATA       (RDATA),
        .BUS_ERR     (BUS_ERR),
        .wb          (wb)
    );

    always #5 CLK = ~CLK;

    // Synchronizer outputs: set by a TCK-side toggle, cleared by the pulse.
    logic req_tog = 1'b0, req_tog_q = 1'b0, err_tog = 1'b0, err_tog_q = 1'b0;
    always @(posedge CLK) begin
        req_tog_q <= req_tog;
        err_tog_q <= err_tog;
        if (req_tog != req_tog_q) REQ_DET <= 1'b1;
        else if (REQ_CLR)         REQ_DET <= 1'b0;
        if (err_tog != err_tog_q) ERR_CLR_DET <= 1'b1;
        else if (ERR_CLR)         ERR_CLR_DET <= 1'b0;
    end

    // Slave: mode 0 = ACK after slv_waits, 1 = never answers, 2 = ACK+ERR.
    int          slv_waits = 0;
    int          slv_mode  = 0;
    int          wcnt      = 0;
    logic [31:0] slv_rdata = '0;
    always @(negedge CLK) begin
        wb.WB_DAT_I = slv_rdata;
        if (wb.WB_CYC_O && wb.WB_STB_O) begin
            if (wcnt >= slv_waits && slv_mode != 1) begin
                wb.WB_ACK_I = 1'b1;
                wb.WB_ERR_I = (slv_mode == 2);
            end else begin
                wb.WB_ACK_I = 1'b0;
                wb.WB_ERR_I = 1'b0;
                wcnt = wcnt + 1;
            end
        end else begin
            wb.WB_ACK_I = 1'b0;
            wb.WB_ERR_I = 1'b0;
            wcnt = 0;
        end
    end

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic        exp_tog = 1'b0;
    logic [31:0] cap_adr, cap_dat;
    logic [3:0]  cap_sel;
    logic        cap_we;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request (optionally with an error-clear) and check handshake timing.
    task automatic xfer(input string tag, input logic first, input logic [31:0] addr,
                        input logic we, input logic [1:0] size, input logic [31:0] wdata,
                        input logic clr_too, input int exp_lat, input int exp_cyc,
                        input logic exp_err);
        logic prev;
        bit   seen;
        int   cyc_cnt, rc_cnt, ec_cnt, lat;
        XFER_FIRST = first;
        XFER_ADDR  = addr;
        XFER_WE    = we;
        XFER_SIZE  = size;
        XFER_WDATA = wdata;
        prev = ACK_TOGGLE;
        seen = 0; cyc_cnt = 0; rc_cnt = 0; ec_cnt = 0; lat = 0;
        cap_adr = '0; cap_dat = '0; cap_sel = '0; cap_we = 1'b0;
        req_tog = ~req_tog;
        if (clr_too) err_tog = ~err_tog;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (wb.WB_CYC_O) begin
                if (cyc_cnt == 0) begin
                    cap_adr = wb.WB_ADR_O;
                    cap_dat = wb.WB_DAT_O;
                    cap_sel = wb.WB_SEL_O;
                    cap_we  = wb.WB_WE_O;
                end
                cyc_cnt = cyc_cnt + 1;
            end
            if (REQ_CLR) rc_cnt = rc_cnt + 1;
            if (ERR_CLR) ec_cnt = ec_cnt + 1;
            if (ACK_TOGGLE !== prev) begin
                seen = 1;
                lat  = i;
                break;
            end
        end
        exp_tog = ~exp_tog;
        chk({tag, "/toggle_seen"}, 32'(seen), 32'd1);
        chk({tag, "/latency"},     32'(lat), 32'(exp_lat));
        chk({tag, "/cyc_cycles"},  32'(cyc_cnt), 32'(exp_cyc));
        chk({tag, "/req_clr_cnt"}, 32'(rc_cnt), 32'd1);
        chk({tag, "/err_clr_cnt"}, 32'(ec_cnt), 32'(clr_too));
        chk({tag, "/ack_toggle"},  32'(ACK_TOGGLE), 32'(exp_tog));
        chk({tag, "/bus_err"},     32'(BUS_ERR), 32'(exp_err));
    endtask

    task automatic clr_err(input string tag);
        int ec;
        ec = 0;
        err_tog = ~err_tog;
        repeat (6) begin
            @(negedge CLK);
            if (ERR_CLR) ec = ec + 1;
        end
        chk({tag, "/err_clr_cnt"}, 32'(ec), 32'd1);
        chk({tag, "/bus_err"},     32'(BUS_ERR), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst/ack_toggle", 32'(ACK_TOGGLE), 32'd0);
        chk("rst/rdata",      RDATA, 32'd0);
        chk("rst/bus_err",    32'(BUS_ERR), 32'd0);
        chk("rst/req_clr",    32'(REQ_CLR), 32'd0);
        chk("rst/err_clr",    32'(ERR_CLR), 32'd0);
        chk("rst/cyc",        32'(wb.WB_CYC_O), 32'd0);
        chk("rst/stb",        32'(wb.WB_STB_O), 32'd0);
        chk("rst/adr",        wb.WB_ADR_O, 32'd0);
        chk("rst/sel",        32'(wb.WB_SEL_O), 32'd0);
        chk("rst/cti_bte",    32'({wb.WB_CTI_O, wb.WB_BTE_O}), 32'd0);
        RSTN = 1'b1;
        @(negedge CLK);

        // Word write with three wait states.
        slv_waits = 3;
        xfer("wr_word", 1'b1, 32'h1000_0004, 1'b1, SZ_WORD, 32'hDEAD_BEEF, 1'b0, 6, 4, 1'b0);
        chk("wr_word/sel",   32'(cap_sel), 32'hF);
        chk("wr_word/dat",   cap_dat, 32'hDEAD_BEEF);
        chk("wr_word/adr",   cap_adr, 32'h1000_0004);
        chk("wr_word/we",    32'(cap_we), 32'd1);
        chk("wr_word/rdata", RDATA, 32'd0);
        slv_waits = 0;

        xfer("wr_byte", 1'b1, 32'h0000_0021, 1'b1, SZ_BYTE, 32'h0000_00A5, 1'b0, 3, 1, 1'b0);
        chk("wr_byte/sel", 32'(cap_sel), 32'h4);
        chk("wr_byte/dat", cap_dat, 32'hA5A5_A5A5);
        xfer("wr_half", 1'b1, 32'h0000_0022, 1'b1, SZ_HALF, 32'h0000_BEEF, 1'b0, 3, 1, 1'b0);
        chk("wr_half/sel", 32'(cap_sel), 32'h3);
        chk("wr_half/dat", cap_dat, 32'hBEEF_BEEF);

        // Byte-read burst from offset 1; later requests ignore XFER_ADDR.
        slv_rdata = 32'h1122_3344;
        xfer("rd_b1", 1'b1, 32'h0000_0001, 1'b0, SZ_BYTE, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("rd_b1/sel", 32'(cap_sel), 32'h4);
        chk("rd_b1/adr", cap_adr, 32'h1);
        chk("rd_b1/we",  32'(cap_we), 32'd0);
        chk("rd_b1/rdata", RDATA, 32'h22);
        xfer("rd_b2", 1'b0, 32'hABCD_0000, 1'b0, SZ_BYTE, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("rd_b2/sel", 32'(cap_sel), 32'h2);
        chk("rd_b2/adr", cap_adr, 32'h2);
        chk("rd_b2/rdata", RDATA, 32'h33);
        xfer("rd_b3", 1'b0, 32'hABCD_0000, 1'b0, SZ_BYTE, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("rd_b3/sel", 32'(cap_sel), 32'h1);
        chk("rd_b3/adr", cap_adr, 32'h3);
        chk("rd_b3/rdata", RDATA, 32'h44);
        xfer("rd_b4", 1'b0, 32'hABCD_0000, 1'b0, SZ_BYTE, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("rd_b4/sel", 32'(cap_sel), 32'h8);
        chk("rd_b4/adr", cap_adr, 32'h4);
        chk("rd_b4/rdata", RDATA, 32'h11);

        xfer("rd_h2", 1'b1, 32'h0000_0002, 1'b0, SZ_HALF, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("rd_h2/sel", 32'(cap_sel), 32'h3);
        chk("rd_h2/rdata", RDATA, 32'h3344);
        xfer("rd_h0", 1'b1, 32'h0000_0000, 1'b0, SZ_HALF, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("rd_h0/sel", 32'(cap_sel), 32'hC);
        chk("rd_h0/rdata", RDATA, 32'h1122);

        // Next-address wraps past the top of the address space.
        slv_rdata = 32'hCAFE_F00D;
        xfer("wrap1", 1'b1, 32'hFFFF_FFFC, 1'b0, SZ_WORD, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("wrap1/adr", cap_adr, 32'hFFFF_FFFC);
        chk("wrap1/rdata", RDATA, 32'hCAFE_F00D);
        slv_rdata = 32'h0BAD_F00D;
        xfer("wrap2", 1'b0, 32'h1234_5670, 1'b0, SZ_WORD, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("wrap2/adr", cap_adr, 32'h0000_0000);
        chk("wrap2/rdata", RDATA, 32'h0BAD_F00D);

        // Timeout, then a rejected request while the error is sticky.
        slv_mode = 1;
        xfer("tmo", 1'b1, 32'h0000_0100, 1'b0, SZ_WORD, 32'd0, 1'b0, 10, 8, 1'b1);
        chk("tmo/rdata", RDATA, 32'h0BAD_F00D);
        slv_mode = 0;
        xfer("sticky", 1'b0, 32'h0, 1'b0, SZ_WORD, 32'd0, 1'b0, 2, 0, 1'b1);
        clr_err("clr1");
        slv_rdata = 32'h7654_3210;
        xfer("after_clr", 1'b0, 32'h0, 1'b0, SZ_WORD, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("after_clr/adr", cap_adr, 32'h4);
        chk("after_clr/rdata", RDATA, 32'h7654_3210);

        // Rejected accesses: misaligned half, reserved size, misaligned word.
        xfer("half_mis", 1'b1, 32'h0000_0003, 1'b1, SZ_HALF, 32'h1234, 1'b0, 2, 0, 1'b1);
        clr_err("clr2");
        xfer("size3", 1'b1, 32'h0000_0000, 1'b0, SZ_RSVD, 32'd0, 1'b0, 2, 0, 1'b1);
        clr_err("clr3");
        xfer("word_mis", 1'b1, 32'h0000_0002, 1'b0, SZ_WORD, 32'd0, 1'b0, 2, 0, 1'b1);
        clr_err("clr4");

        // ACK and ERR together: error wins, read data untouched.
        slv_mode  = 2;
        slv_rdata = 32'h5555_5555;
        xfer("ack_err", 1'b1, 32'h0000_0300, 1'b0, SZ_WORD, 32'd0, 1'b0, 3, 1, 1'b1);
        chk("ack_err/rdata", RDATA, 32'h7654_3210);

        // Clear and request together: clear first, request next cycle.
        slv_mode  = 0;
        slv_rdata = 32'h1357_9BDF;
        xfer("clr_req", 1'b0, 32'h0, 1'b0, SZ_WORD, 32'd0, 1'b1, 4, 1, 1'b0);
        chk("clr_req/adr", cap_adr, 32'h8);
        chk("clr_req/rdata", RDATA, 32'h1357_9BDF);

        // Asynchronous reset in the middle of a bus cycle.
        slv_mode   = 1;
        XFER_FIRST = 1'b1;
        XFER_ADDR  = 32'h0000_0080;
        XFER_WE    = 1'b0;
        XFER_SIZE  = SZ_WORD;
        req_tog    = ~req_tog;
        repeat (4) @(negedge CLK);
        chk("rst_mid/cyc_before", 32'(wb.WB_CYC_O), 32'd1);
        #2 RSTN = 1'b0;
        #1;
        chk("rst_mid/cyc",     32'(wb.WB_CYC_O), 32'd0);
        chk("rst_mid/stb",     32'(wb.WB_STB_O), 32'd0);
        chk("rst_mid/adr",     wb.WB_ADR_O, 32'd0);
        chk("rst_mid/toggle",  32'(ACK_TOGGLE), 32'd0);
        chk("rst_mid/rdata",   RDATA, 32'd0);
        chk("rst_mid/bus_err", 32'(BUS_ERR), 32'd0);
        exp_tog = 1'b0;
        @(negedge CLK);
        RSTN     = 1'b1;
        slv_mode = 0;
        repeat (2) @(negedge CLK);
        chk("rst_mid/no_toggle", 32'(ACK_TOGGLE), 32'd0);
        slv_rdata = 32'h89AB_CDEF;
        xfer("post_rst", 1'b1, 32'h0000_0040, 1'b0, SZ_WORD, 32'd0, 1'b0, 3, 1, 1'b0);
        chk("post_rst/adr", cap_adr, 32'h40);
        chk("post_rst/rdata", RDATA, 32'h89AB_CDEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
